// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl - bit-timing controller for the UART receive path.
//
// Starts a frame on the one-cycle start-edge strobe from the capture stage,
// runs a baud counter and emits a one-cycle mid-bit sample strobe together
// with the index of the bit being sampled (0 = start, 1..8 = data LSB first,
// 9 = stop). A stop bit sampled low raises a one-cycle framing-error pulse.
//
// Optional feature macro: UART_RX_START_CHECK_EN
//   defined   : the line is re-checked at the start-bit sample point; a high
//               line (false start) suppresses that strobe and drops the frame.
//   undefined : no start-bit check, every frame runs to completion.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active-high
//   rx_en        in   start-edge strobe (one cycle)
//   rs232_rx     in   raw serial line (start/stop checks only)
//   rx_sel_data  out  one-cycle mid-bit sample strobe
//   rx_num       out  bit index 0..9, valid while rx_busy
//   rx_busy      out  frame in progress
//   frame_err    out  one-cycle pulse, stop bit sampled low
module uart_rx_ctrl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       rs232_rx,
  output logic       rx_sel_data,
  output logic [3:0] rx_num,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT);

  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  // DONE is the single cycle after the final strobe (or an aborted start);
  // rx_en is ignored there, so a start edge on the return-to-idle edge is dropped.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          start_bad;

  // False-start detection: high line at the start-bit sample point.
`ifdef UART_RX_START_CHECK_EN
  assign start_bad = rs232_rx;
`else
  assign start_bad = 1'b0;
`endif

  // Frame sequencer: baud counter, bit index, strobe and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= CNT_ZERO;
      rx_num      <= 4'd0;
      rx_sel_data <= 1'b0;
      rx_busy     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      // Strobe and error are single-cycle pulses by default.
      rx_sel_data <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_en) begin
            state   <= RUN;
            cnt     <= CNT_ZERO;
            rx_num  <= 4'd0;
            rx_busy <= 1'b1;
          end else begin
            state   <= IDLE;
          end
        end
        RUN: begin
          if (cnt == CNT_LAST) begin
            cnt    <= CNT_ZERO;
            rx_num <= rx_num + 4'd1;
          end else begin
            cnt    <= cnt + {{(CW-1){1'b0}}, 1'b1};
          end
          if (cnt == CNT_MID) begin
            if ((rx_num == 4'd0) && start_bad) begin
              // False start: no strobe for this frame at all.
              state <= DONE;
            end else begin
              rx_sel_data <= 1'b1;
              if (rx_num == 4'd9) begin
                // Stop sample: leave half a bit early so the next start edge is seen.
                state     <= DONE;
                frame_err <= ~rs232_rx;
              end else begin
                state     <= RUN;
              end
            end
          end else begin
            state <= RUN;
          end
        end
        DONE: begin
          state   <= IDLE;
          cnt     <= CNT_ZERO;
          rx_num  <= 4'd0;
          rx_busy <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          cnt     <= CNT_ZERO;
          rx_num  <= 4'd0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
